// File: rtl/fetch_sequencer.sv
// Multicycle fetch/execute sequencer: owns the PC, issues instruction and data requests, computes next PC.
// Optional retired-instruction counter on port instret is enabled by defining FETCH_INSTRET_EN.
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        halt,
    input  logic        bne,
    input  logic [2:0]  jsel,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        wb_en,
    output logic        halted
`ifdef FETCH_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] instr_reg;
    logic [31:0] pc_target;
    logic [31:0] branch_off;
    logic        load_ir;
    logic        load_pc;
    logic        taken;

    assign imemaddr    = pc;
    assign pc_plus4    = pc + 32'd4;
    assign instruction = instr_reg;
    assign halted      = (state == HALTED);

    assign branch_off = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign taken      = bne ? ~zero : zero;

    always_comb begin
        pc_target = pc_plus4;
        case (jsel)
            3'd1:    pc_target = taken ? (pc_plus4 + branch_off) : pc_plus4;
            3'd2:    pc_target = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
            3'd3:    pc_target = jr_target;
            default: pc_target = pc_plus4;
        endcase
    end

    // Request strobes depend only on state and the current decode, so they stay stable until the hit.
    always_comb begin
        state_next = state;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        wb_en      = 1'b0;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    load_ir    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                dmemWEN = dWEN;
                dmemREN = dREN & ~dWEN;
                if (!(dREN || dWEN) || dhit) begin
                    if (halt) begin
                        state_next = HALTED;
                    end else begin
                        wb_en      = 1'b1;
                        load_pc    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            instr_reg <= 32'h0;
        end else begin
            state <= state_next;
            if (load_ir) instr_reg <= imemload;
            if (load_pc) pc <= pc_target;
        end
    end

`ifdef FETCH_INSTRET_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) instret <= 32'h0;
        else if (wb_en) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the fetch/execute rules.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0, dhit = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic        halt = 1'b0, bne = 1'b0, zero = 1'b0;
    logic [2:0]  jsel = 3'd0;
    logic [31:0] imemload = 32'h0, jr_target = 32'h0;
    logic        imemREN, dmemREN, dmemWEN, wb_en, halted;
    logic [31:0] imemaddr, instruction, pc_plus4;
`ifdef FETCH_INSTRET_EN
    logic [31:0] instret;
`endif

    fetch_sequencer #(.PC_RESET(32'h0)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
        .dREN(dREN), .dWEN(dWEN), .halt(halt), .bne(bne), .jsel(jsel), .zero(zero),
        .jr_target(jr_target), .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .instruction(instruction),
        .pc_plus4(pc_plus4), .wb_en(wb_en), .halted(halted)
`ifdef FETCH_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: 0 = waiting for instruction, 1 = executing, 2 = halted.
    int          mode = 0;
    logic [31:0] mpc = 32'h0, minstr = 32'h0, mret = 32'h0;
    int          checks = 0, failures = 0;
    int          dmemRenCycles = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refNextPc();
        logic [31:0] seq;
        int          off;
        seq = mpc + 32'd4;
        case (jsel)
            3'd1: begin
                off = int'($signed(minstr[15:0])) * 4;
                if (bne ? !zero : zero) return seq + 32'(off);
                return seq;
            end
            3'd2: return (seq & 32'hF000_0000) | ({6'b0, minstr[25:0]} * 32'd4);
            3'd3: return jr_target;
            default: return seq;
        endcase
    endfunction

    task automatic modelReset();
        mode = 0; mpc = 32'h0; minstr = 32'h0; mret = 32'h0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
    task automatic applyStimulus(input logic i_ihit, input logic [31:0] i_load, input logic i_dhit,
                                 input logic i_dren, input logic i_dwen, input logic i_halt,
                                 input logic i_bne, input logic [2:0] i_jsel, input logic i_zero,
                                 input logic [31:0] i_jr);
        logic completes;
        ihit = i_ihit; imemload = i_load; dhit = i_dhit; dREN = i_dren; dWEN = i_dwen;
        halt = i_halt; bne = i_bne; jsel = i_jsel; zero = i_zero; jr_target = i_jr;
        #1;
        completes = !(dREN || dWEN) || dhit;
        checkOutput("imemREN", imemREN, 32'(mode == 0));
        if (mode == 0) checkOutput("imemaddr", imemaddr, mpc);
        checkOutput("dmemREN", dmemREN, 32'(mode == 1 && dREN && !dWEN));
        checkOutput("dmemWEN", dmemWEN, 32'(mode == 1 && dWEN));
        checkOutput("instruction", instruction, minstr);
        checkOutput("pc_plus4", pc_plus4, mpc + 32'd4);
        checkOutput("wb_en", wb_en, 32'(mode == 1 && completes && !halt));
        checkOutput("halted", halted, 32'(mode == 2));
`ifdef FETCH_INSTRET_EN
        checkOutput("instret", instret, mret);
`endif
        if (dmemREN) dmemRenCycles++;
        @(posedge CLK);
        if (nRST) begin
            if (mode == 0 && ihit) begin
                minstr = imemload;
                mode = 1;
            end else if (mode == 1 && completes) begin
                if (halt) mode = 2;
                else begin
                    mpc = refNextPc();
                    mret = mret + 32'd1;
                    mode = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic runInstr(input logic [31:0] word, input logic dren, input logic dwen,
                            input logic hlt, input logic bn, input logic [2:0] js,
                            input logic zr, input logic [31:0] jr, input int waitCycles);
        applyStimulus(1'b1, word, 1'b0, dren, dwen, hlt, bn, js, zr, jr);
        for (int i = 0; i < waitCycles; i++)
            applyStimulus(1'b0, $urandom, 1'b0, dren, dwen, hlt, bn, js, zr, jr);
        applyStimulus(1'b0, $urandom, 1'b1, dren, dwen, hlt, bn, js, zr, jr);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_imemREN"}, imemREN, 32'h1);
        checkOutput({tag, "_imemaddr"}, imemaddr, 32'h0);
        checkOutput({tag, "_dmemREN"}, dmemREN, 32'h0);
        checkOutput({tag, "_dmemWEN"}, dmemWEN, 32'h0);
        checkOutput({tag, "_wb_en"}, wb_en, 32'h0);
        checkOutput({tag, "_halted"}, halted, 32'h0);
    endtask

    // Asserts nRST asynchronously, checks the reset outputs, and releases on the next falling edge.
    task automatic doReset(input string tag);
        #2;
        nRST = 1'b0;
        #1;
        modelReset();
        checkResetState(tag);
        checkOutput({tag, "_instruction"}, instruction, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    logic        r_dren, r_dwen, r_halt, r_bne, r_zero;
    logic [2:0]  r_jsel;
    logic [31:0] r_jr;
    int          haltedCycles;

    initial begin
        @(negedge CLK);
        doReset("reset");

        // First instruction straight out of reset, ihit on the first cycle.
        runInstr(32'h1234_5678, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
        checkOutput("ir_after_reset", instruction, 32'h1234_5678);
        checkOutput("pc_after_first", imemaddr, 32'h4);

        // Load with dhit on the third cycle of the request.
        dmemRenCycles = 0;
        runInstr(32'h8C01_0000, 1, 0, 0, 0, 3'd0, 0, 32'h0, 2);
        checkOutput("load_dmemREN_cycles", 32'(dmemRenCycles), 32'd3);
        checkOutput("pc_after_load", imemaddr, 32'h8);

        // Conditional branches from PC=0x100 with imm=-2.
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'h100, 0);
        checkOutput("jr_0x100", imemaddr, 32'h100);
        runInstr(32'h1000_FFFE, 0, 0, 0, 0, 3'd1, 1, 32'h0, 0);
        checkOutput("beq_taken", imemaddr, 32'h0FC);
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'h100, 0);
        runInstr(32'h1000_FFFE, 0, 0, 0, 0, 3'd1, 0, 32'h0, 0);
        checkOutput("beq_not_taken", imemaddr, 32'h104);
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'h100, 0);
        runInstr(32'h1400_FFFE, 0, 0, 0, 1, 3'd1, 1, 32'h0, 0);
        checkOutput("bne_not_taken", imemaddr, 32'h104);
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'h100, 0);
        runInstr(32'h1400_FFFE, 0, 0, 0, 1, 3'd1, 0, 32'h0, 0);
        checkOutput("bne_taken", imemaddr, 32'h0FC);

        // J keeps the upper nibble of PC+4; JR loads the register value.
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'hF000_0000, 0);
        runInstr(32'h0800_0001, 0, 0, 0, 0, 3'd2, 0, 32'h0, 0);
        checkOutput("j_target", imemaddr, 32'hF000_0004);
        runInstr(32'h0, 0, 0, 0, 0, 3'd3, 0, 32'h40, 0);
        checkOutput("jr_target", imemaddr, 32'h40);
        runInstr(32'h0, 0, 0, 0, 0, 3'd5, 1, 32'h0, 0);
        checkOutput("reserved_jsel", imemaddr, 32'h44);

        // Reset while a store waits for dhit.
        applyStimulus(1'b1, 32'hAC01_0000, 1'b0, 0, 1, 0, 0, 3'd0, 0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 0, 1, 0, 0, 3'd0, 0, 32'h0);
        checkOutput("store_pending", dmemWEN, 32'h1);
        dhit = 1'b1;
        doReset("reset_mid_store");
        runInstr(32'h0000_0020, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
        checkOutput("pc_after_store_reset", imemaddr, 32'h4);

        // Halt: no writeback, no further fetches, exit only through reset.
        runInstr(32'hFFFF_FFFF, 0, 0, 1, 0, 3'd0, 0, 32'h0, 0);
        checkOutput("halted_flag", halted, 32'h1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, 1'b1, 0, 0, 0, 0, 3'd0, 0, 32'h0);
        doReset("reset_mid_halted");

        // Randomized traffic; decode is held steady for the whole instruction.
        haltedCycles = 0;
        r_dren = 0; r_dwen = 0; r_halt = 0; r_bne = 0; r_zero = 0; r_jsel = 0; r_jr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (mode == 2 && haltedCycles >= 4) begin
                haltedCycles = 0;
                doReset("reset_random");
            end else begin
                if (mode == 2) haltedCycles++;
                if (mode == 0) begin
                    r_dren = ($urandom_range(3) == 0);
                    r_dwen = ($urandom_range(3) == 0);
                    r_halt = ($urandom_range(49) == 0);
                    r_bne  = 1'($urandom);
                    r_zero = 1'($urandom);
                    r_jsel = 3'($urandom);
                    r_jr   = $urandom & 32'hFFFF_FFFC;
                end
                applyStimulus(($urandom_range(2) == 0), $urandom, ($urandom_range(2) == 0),
                              r_dren, r_dwen, r_halt, r_bne, r_jsel, r_zero, r_jr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
